// File: rtl/vedic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vedic_pkg
//  Description : Shared widths and the operand-entry type for the shared
//                vedic multiplier arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package vedic_pkg;

    localparam int VEDIC_OPW     = 8;    // operand width
    localparam int VEDIC_PW      = 16;   // product width
    localparam int VEDIC_IDW_MAX = 3;    // enough id bits for up to 8 requesters

    // One granted operand pair, tagged with the requester that owns it
    typedef struct packed {
        logic [VEDIC_IDW_MAX-1:0] id;
        logic [VEDIC_OPW-1:0]     a;
        logic [VEDIC_OPW-1:0]     b;
    } vedic_op_t;

endpackage
`default_nettype wire

// File: rtl/vedic_8X8.sv
`default_nettype none
// ============================================================================
//  Module      : vedic_8X8
//  Description : Combinational 8x8 unsigned multiplier built the vedic way:
//                2x2 crosswise cells combined into 4x4, then into 8x8.
//  Revision    : 1.0 - initial release
// ============================================================================
module vedic_8X8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    // 2x2 vertical-and-crosswise cell
    function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
        logic [1:0] mid;
        logic [1:0] hi;
        mid = {1'b0, x[1] & y[0]} + {1'b0, x[0] & y[1]};
        hi  = {1'b0, x[1] & y[1]} + {1'b0, mid[1]};
        return {hi, mid[0], x[0] & y[0]};
    endfunction

    // 4x4 from four 2x2 partial products
    function automatic logic [7:0] vm4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] q0, q1, q2, q3;
        q0 = vm2(x[1:0], y[1:0]);
        q1 = vm2(x[3:2], y[1:0]);
        q2 = vm2(x[1:0], y[3:2]);
        q3 = vm2(x[3:2], y[3:2]);
        return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
    endfunction

    logic [7:0] w_q0, w_q1, w_q2, w_q3;

    // 8x8 from four 4x4 partial products, aligned and summed
    always_comb begin
        w_q0 = vm4(a[3:0], b[3:0]);
        w_q1 = vm4(a[7:4], b[3:0]);
        w_q2 = vm4(a[3:0], b[7:4]);
        w_q3 = vm4(a[7:4], b[7:4]);
        p    = {8'b0, w_q0} + {4'b0, w_q1, 4'b0} + {4'b0, w_q2, 4'b0} + {w_q3, 8'b0};
    end

endmodule
`default_nettype wire

// File: rtl/vedic_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vedic_mul_arbiter
//  Description : Round-robin arbiter sharing one vedic_8X8 multiplier among
//                NREQ requesters; returns id-tagged products on a
//                valid/ready response channel and counts completions.
//                Define VEDIC_ARB_PIPE_EN to add an operand register stage
//                ahead of the multiplier (latency 2 instead of 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module vedic_mul_arbiter
    import vedic_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [VEDIC_OPW*NREQ-1:0] req_a,
    input  logic [VEDIC_OPW*NREQ-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic [VEDIC_PW-1:0]       rsp_p,
    output logic [15:0]               done_cnt
);

    // Scan from the pointer upward (mod NREQ); returns {found, index}
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IDW-1:0]  p);
        logic [IDW:0] r;
        int           j;
        r = '0;
        // walk downward so the nearest requester after the pointer wins last
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(p) + k) % NREQ;
            if (v[j]) r = {1'b1, IDW'(j)};
        end
        return r;
    endfunction

    logic [IDW-1:0]      r_ptr;
    logic [IDW:0]        w_pick;
    logic                w_acc;
    logic                w_grant;
    logic [IDW-1:0]      w_gidx;
    vedic_op_t           w_op;
    logic [VEDIC_OPW-1:0] w_mul_a;
    logic [VEDIC_OPW-1:0] w_mul_b;
    logic [VEDIC_PW-1:0] w_prod;
    logic                w_unused;

`ifdef VEDIC_ARB_PIPE_EN
    logic                r_s1_valid;
    vedic_op_t           r_s1;
    logic                w_adv;

    // Stage 1 moves on whenever the response register is empty or draining
    assign w_adv    = !rsp_valid || rsp_ready;
    assign w_acc    = !r_s1_valid || w_adv;
    assign w_mul_a  = r_s1.a;
    assign w_mul_b  = r_s1.b;
    assign w_unused = ^{w_op.id, r_s1.id};
`else
    assign w_acc    = !rsp_valid || rsp_ready;
    assign w_mul_a  = w_op.a;
    assign w_mul_b  = w_op.b;
    assign w_unused = ^w_op.id;
`endif

    // Grant selection and operand mux; nothing is granted during reset
    always_comb begin
        w_pick    = rr_pick(req_valid, r_ptr);
        w_grant   = w_pick[IDW] && w_acc && !rst;
        w_gidx    = w_pick[IDW-1:0];
        req_ready = w_grant ? (NREQ'(1) << w_gidx) : '0;
        w_op.id   = VEDIC_IDW_MAX'(w_gidx);
        w_op.a    = req_a[int'(w_gidx)*VEDIC_OPW +: VEDIC_OPW];
        w_op.b    = req_b[int'(w_gidx)*VEDIC_OPW +: VEDIC_OPW];
    end

    vedic_8X8 u_mul (
        .a (w_mul_a),
        .b (w_mul_b),
        .p (w_prod)
    );

    // Priority pointer advances past each granted requester
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
        end
    end

`ifdef VEDIC_ARB_PIPE_EN
    // Operand stage: load on every accept, empties when nothing is granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_acc) begin
            r_s1_valid <= w_grant;
            if (w_grant) r_s1 <= w_op;
        end
    end

    // Response register fed from the operand stage through the multiplier
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_p     <= '0;
            rsp_id    <= '0;
        end else if (w_adv) begin
            rsp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                rsp_p  <= w_prod;
                rsp_id <= r_s1.id[IDW-1:0];
            end
        end
    end
`else
    // Response register loaded straight from the grant mux and multiplier
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_p     <= '0;
            rsp_id    <= '0;
        end else if (w_acc) begin
            rsp_valid <= w_grant;
            if (w_grant) begin
                rsp_p  <= w_prod;
                rsp_id <= w_gidx;
            end
        end
    end
`endif

    // Saturating count of response transfers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt <= '0;
        end else if (rsp_valid && rsp_ready && (done_cnt != 16'hFFFF)) begin
            done_cnt <= done_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vedic_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vedic_mul_arbiter
//  Description : Self-checking bench for vedic_mul_arbiter (default build,
//                single-cycle latency) with a cycle-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vedic_mul_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [8*N-1:0] req_a;
    logic [8*N-1:0] req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [15:0]   rsp_p;
    logic [15:0]   done_cnt;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_ptr;
    bit m_valid;
    int m_p;
    int m_id;
    int m_cnt;

    always #5 clk = ~clk;

    vedic_mul_arbiter #(.NREQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .done_cnt  (done_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // first valid requester at or after p, wrapping; -1 if none
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int exp_ready();
        int g;
        if (m_valid && !rsp_ready) return 0;
        g = pick(req_valid, m_ptr);
        return (g < 0) ? 0 : (1 << g);
    endfunction

    // model: one accepted request per cycle becomes next cycle's response
    always @(posedge clk or posedge rst) begin
        int g;
        if (rst) begin
            m_ptr   <= 0;
            m_valid <= 1'b0;
            m_p     <= 0;
            m_id    <= 0;
            m_cnt   <= 0;
        end else begin
            if (m_valid && rsp_ready && m_cnt < 65535) m_cnt <= m_cnt + 1;
            if (!m_valid || rsp_ready) begin
                g = pick(req_valid, m_ptr);
                if (g >= 0) begin
                    m_valid <= 1'b1;
                    m_p     <= int'(req_a[8*g +: 8]) * int'(req_b[8*g +: 8]);
                    m_id    <= g;
                    m_ptr   <= (g + 1) % N;
                end else begin
                    m_valid <= 1'b0;
                end
            end
        end
    end

    // every-cycle comparison against the model, away from the clock edge
    always @(negedge clk) begin
        if (!rst) begin
            check("req_ready", int'(req_ready), exp_ready());
            check("rsp_valid", int'(rsp_valid), int'(m_valid));
            if (m_valid) begin
                check("rsp_p", int'(rsp_p), m_p);
                check("rsp_id", int'(rsp_id), m_id);
            end
            check("done_cnt", int'(done_cnt), m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // single request from requester i, product checked against a literal
    task automatic single(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp);
        tick();
        req_valid    = N'(1) << i;
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
        @(negedge clk);
        check("single_grant", int'(req_ready), 1 << i);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("single_valid", int'(rsp_valid), 1);
        check("single_p", int'(rsp_p), int'(exp));
        check("single_id", int'(rsp_id), i);
    endtask

    int exp_grant [5]  = '{1, 2, 4, 8, 1};
    int exp_prod  [4]  = '{200, 231, 264, 299};

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_req_ready", int'(req_ready), 0);
        check("reset_done_cnt", int'(done_cnt), 0);
        check("reset_rsp_p", int'(rsp_p), 0);
        tick();
        rst = 1'b0;

        // single request and corner operands
        single(2, 8'd200, 8'd150, 16'h7530);
        single(1, 8'd255, 8'd255, 16'hFE01);
        single(3, 8'd0,   8'd173, 16'h0000);
        single(0, 8'd1,   8'd255, 16'h00FF);
        @(negedge clk);
        check("done_after_singles", int'(done_cnt), 4);

        // contention from reset: grants 0,1,2,3,0 with products in order
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_a[8*i +: 8] = 8'(10 + i);
            req_b[8*i +: 8] = 8'(20 + i);
        end
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("contend_grant", int'(req_ready), exp_grant[k]);
            if (k > 0) begin
                check("contend_id", int'(rsp_id), (k - 1) % N);
                check("contend_p", int'(rsp_p), exp_prod[(k - 1) % N]);
            end
            @(posedge clk);
        end

        // backpressure for five cycles, then resume streaming
        #1;
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_req_ready", int'(req_ready), 0);
            check("bp_rsp_valid", int'(rsp_valid), 1);
        end
        tick();
        rsp_ready = 1'b1;
        repeat (8) @(posedge clk);

        // asynchronous reset in the middle of back-to-back traffic
        #2;
        rst = 1'b1;
        #1;
        check("arst_rsp_valid", int'(rsp_valid), 0);
        check("arst_rsp_p", int'(rsp_p), 0);
        check("arst_rsp_id", int'(rsp_id), 0);
        check("arst_done_cnt", int'(done_cnt), 0);
        check("arst_req_ready", int'(req_ready), 0);
        tick();
        req_valid = 4'b1010;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_grant", int'(req_ready), 4'b0010);
        tick();
        req_valid = '0;

        // saturation of the completion counter
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = '1;
        repeat (65540) @(posedge clk);
        @(negedge clk);
        check("sat_done_cnt", int'(done_cnt), 16'hFFFF);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("sat_hold", int'(done_cnt), 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vedic_mul_arbiter.md
# vedic_mul_arbiter

Round-robin arbiter and sequencer that shares one `vedic_8X8` combinational multiplier among NREQ requesters. Each requester offers an 8x8 unsigned operand pair over a valid/ready handshake. The block grants one requester per cycle, drives the winning operands into the shared multiplier, and returns the 16-bit product tagged with the requester index over a valid/ready response channel. It sits between the requesting datapath blocks and the single multiplier instance, replacing per-client multiplier copies.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8.
- IDW, $clog2(NREQ): width of the response ID.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  NREQ  bit i set: requester i offers an operand pair.
- req_ready  out  NREQ  one-hot or zero; bit i set: requester i is granted this cycle.
- req_a  in  8*NREQ  multiplicand; requester i uses bits [8i+7:8i].
- req_b  in  8*NREQ  multiplier; same packing as req_a.
- rsp_valid  out  1  response register holds a product.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  index of the requester that owns rsp_p.
- rsp_p  out  16  product req_a*req_b, unsigned, no truncation.
- done_cnt  out  16  count of completed responses; saturates at 0xFFFF.

## Operation
- Handshake: a request transfers when req_valid[i] and req_ready[i] are both high. A response transfers when rsp_valid and rsp_ready are both high.
- Accept condition (ACC), without the pipeline stage: !rsp_valid || rsp_ready.
- Grant:
  - When ACC holds, the block scans from priority pointer ptr upward, modulo NREQ.
  - The first i with req_valid[i] set gets req_ready[i].
  - When ACC is low, req_ready is all zero.
  - req_ready depends combinationally on req_valid and ACC. Requesters must not make req_valid depend on req_ready.
- Pointer: on a grant to i, ptr <= (i+1) mod NREQ. With no grant, ptr holds. Wrap from NREQ-1 goes to 0.
- Datapath: the granted operands are muxed into the `vedic_8X8` instance. The product and the index are registered into rsp_p and rsp_id, and rsp_valid is set.
- Backpressure: while rsp_valid && !rsp_ready, rsp_p, rsp_id and rsp_valid hold stable and no new grant is issued.
- Simultaneous drain and grant: when the response transfers in the same cycle as a new grant, the response register reloads and rsp_valid stays 1 (back-to-back, one result per cycle).
- Counter: done_cnt increments on each response transfer and holds at 0xFFFF.
- Requesters may drop req_valid without a grant; there is no penalty and no state change.

## Timing
- Latency: grant cycle N, rsp_valid in cycle N+1 (N+2 with the pipeline stage).
- Throughput: one product per cycle while rsp_ready stays high.
- Reset values: rsp_valid=0, rsp_p=0, rsp_id=0, done_cnt=0, ptr=0, pipeline stage empty. req_ready=0 while rst is high.
- Reset mid-operation: in-flight and pending products are discarded, with no response. The first grant after reset starts at requester 0.
- Fairness: a continuously requesting client is served within NREQ grants.

## Configuration
- VEDIC_ARB_PIPE_EN defined:
  - Adds an operand register stage (a, b, id, valid) ahead of the multiplier. Latency becomes 2.
  - ACC becomes !s1_valid || !rsp_valid || rsp_ready.
  - Stage 1 advances into the response register when !rsp_valid || rsp_ready.
  - Full throughput is preserved; the stage never overwrites an unadvanced entry.
- Undefined: the multiplier is fed directly from the grant mux. Latency is 1.

## Structure
- Shared package `vedic_pkg`:
  - Constants VEDIC_OPW=8 and VEDIC_PW=16.
  - A struct typedef for {id, a, b} operand entries.
- One sub-module: the existing `vedic_8X8`, instantiated once and unmodified.
- The round-robin picker stays inline as a function; it needs no separate module.

## Test plan
- Single request: requester 2 sends 200*150 with rsp_ready=1. Expect rsp_p=0x7530, rsp_id=2, one cycle after the grant (two cycles with the pipeline stage).
- Corner operands: 255*255 gives 0xFE01; 0*173 gives 0x0000; 1*255 gives 0x00FF.
- Contention: all four requesters valid continuously from reset. Grants go 0,1,2,3,0 on consecutive cycles, with products returned in the same order.
- Backpressure: hold rsp_ready=0 for 5 cycles with a valid response. rsp_p and rsp_id stay stable, req_ready=0, and done_cnt does not change. Release rsp_ready and streaming resumes with no loss or duplication.
- Reset mid-stream: assert rst during back-to-back traffic. Outputs go to their reset values immediately (asynchronously). After release, the first grant goes to the lowest valid index starting from 0.
- Saturation: force 65537 completions. done_cnt reads 0xFFFF and holds there.
